// File: rtl/imem_loader_pkg.sv
// ============================================================================
//  imem_loader_pkg
//  Shared constants and FSM encoding for the instruction-memory loader.
//  Rev 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

  localparam int          IM_DEPTH       = 1024;
  localparam int          IM_AW          = 10;
  localparam int          WORD_COUNT_W   = 11;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ============================================================================
//  imem_loader_if
//  Byte-stream input and instruction-memory write bus of the loader.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int IM_AW = 10
);
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             im_we;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_wdata;

  // master is the loader; slave is the byte source plus memory
  modport master (
    input  byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// ============================================================================
//  byte_packer
//  Big-endian 4-byte shift register with a 2-bit byte counter.
//  Rev 1.0
// ============================================================================
`default_nettype none

module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] r_byte_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word       <= '0;
      r_byte_cnt <= '0;
    end else if (clear) begin
      word       <= '0;
      r_byte_cnt <= '0;
    end else if (shift_en) begin
      word       <= {word[23:0], byte_in};
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

  // High on the shift that completes a word; the counter wraps back to 0.
  assign word_full = shift_en && (r_byte_cnt == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  imem_loader
//  Loads a big-endian byte stream into instruction memory, holding the CPU.
//  Rev 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int IM_DEPTH = imem_loader_pkg::IM_DEPTH,
  parameter int IM_AW    = imem_loader_pkg::IM_AW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [10:0]         word_count,
  imem_loader_if.master       bus,
  output logic                busy,
  output logic                done,
  output logic                cpu_hold,
  output logic [31:0]         checksum
);

  import imem_loader_pkg::*;

  localparam int CNT_W = IM_AW + 1;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_start_count;
  logic [IM_AW-1:0] r_index;
  logic [31:0]      w_word;
  logic             w_word_full;
  logic             w_start_ok;
  logic             w_abort_ok;
  logic             w_accept;
  logic             w_last_word;
  logic             w_byte_ready;
  logic             w_im_we;
  logic             w_busy;
  logic             w_done;
  logic             w_cpu_hold;

  assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_abort_ok  = abort && ((r_state == RECV) || (r_state == WRITE));
  // byte_ready is only high in RECV, so abort there blocks acceptance
  assign w_accept    = bus.byte_ready && bus.byte_valid && !abort;
  assign w_last_word = ({1'b0, r_index} == (r_count - CNT_W'(1)));

  always_comb begin
    if (32'(word_count) > 32'(IM_DEPTH)) begin
      w_start_count = CNT_W'(IM_DEPTH);
    end else begin
      w_start_count = CNT_W'(word_count);
    end
  end

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_start_ok || w_abort_ok),
    .shift_en  (w_accept),
    .byte_in   (bus.byte_data),
    .word      (w_word),
    .word_full (w_word_full)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next_state = (w_start_count == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (abort) begin
          w_next_state = IDLE;
        end else if (w_word_full) begin
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          w_next_state = IDLE;
        end else if (w_last_word) begin
          w_next_state = DONE;
        end else begin
          w_next_state = RECV;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // alongside the state and line up with it.
  always_comb begin
    w_byte_ready = (w_next_state == RECV);
    w_im_we      = (w_next_state == WRITE);
    w_busy       = (w_next_state == RECV) || (w_next_state == WRITE);
    w_done       = (w_next_state == DONE);
    w_cpu_hold   = (w_next_state != DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      bus.byte_ready <= 1'b0;
      bus.im_we      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cpu_hold       <= 1'b1;
    end else begin
      r_state        <= w_next_state;
      bus.byte_ready <= w_byte_ready;
      bus.im_we      <= w_im_we;
      busy           <= w_busy;
      done           <= w_done;
      cpu_hold       <= w_cpu_hold;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_index  <= '0;
      checksum <= '0;
    end else if (w_start_ok) begin
      r_count  <= w_start_count;
      r_index  <= '0;
      checksum <= '0;
    end else if (r_state == WRITE) begin
      // the strobe is already out in this cycle, so the word counts as written
      checksum <= checksum ^ w_word;
      if (!abort && !w_last_word) begin
        r_index <= r_index + IM_AW'(1);
      end
    end
  end

  assign bus.im_addr  = r_index;
  assign bus.im_wdata = w_word;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  tb_imem_loader
//  Scoreboard bench: expected memory writes queued at stimulus, checked by monitor.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int DEPTH = 1024;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [10:0] word_count = '0;
  logic        busy, done, cpu_hold;
  logic [31:0] checksum;

  imem_loader_if #(.IM_AW(10)) bus();

  imem_loader #(.IM_DEPTH(DEPTH), .IM_AW(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .word_count (word_count),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .cpu_hold   (cpu_hold),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  logic [7:0]  tx_bytes[$];
  logic [31:0] sess_words[$];
  logic [31:0] exp_ck;
  int          wr_session;
  int          last_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.im_we === 1'b1) begin
      checks++;
      wr_session++;
      last_addr = int'(bus.im_addr);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected",
                 bus.im_addr, bus.im_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (int'(bus.im_addr) != e.addr || bus.im_wdata !== e.data) begin
          errors++;
          $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                   bus.im_addr, bus.im_wdata, e.addr, e.data);
        end
      end
    end
  end

  // Reference model: count is clamped to the depth, word i lands at address i,
  // checksum is the XOR of all words of the session.
  task automatic plan_session(input int count, input int n_send);
    int n;
    n = (count > DEPTH) ? DEPTH : count;
    exp_ck = '0;
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.addr = i;
      e.data = sess_words[i];
      exp_q.push_back(e);
      exp_ck ^= sess_words[i];
    end
    for (int i = 0; i < n_send; i++) begin
      logic [31:0] w;
      w = sess_words[i / 4];
      tx_bytes.push_back(w[31 - 8*(i % 4) -: 8]);
    end
  endtask

  task automatic random_words(input int n);
    sess_words.delete();
    for (int i = 0; i < n; i++) sess_words.push_back($urandom);
  endtask

  task automatic start_cmd(input int count);
    wr_session = 0;
    start      = 1'b1;
    word_count = 11'(count);
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic send_bytes(input int mode);
    int guard;
    bit tog;
    bit acc;
    logic v;
    guard = 0;
    tog = 1'b0;
    while (tx_bytes.size() > 0 && guard < 20000) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.byte_valid = v;
      bus.byte_data  = v ? tx_bytes[0] : 8'($urandom);
      acc = v && (bus.byte_ready === 1'b1);
      @(posedge clk); #1;
      if (acc) void'(tx_bytes.pop_front());
      guard++;
    end
    bus.byte_valid = 1'b0;
    if (guard >= 20000) begin
      checks++; errors++;
      $display("FAIL send_timeout: %0d bytes left, required 0", tx_bytes.size());
      tx_bytes.delete();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 8000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 8000) begin
      checks++; errors++;
      $display("FAIL done_timeout: done %b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic end_checks(input int n);
    @(negedge clk);
    check("done", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("cpu_hold_done", 32'(cpu_hold), 32'd0);
    check("checksum", checksum, exp_ck);
    check("write_count", 32'(wr_session), 32'(n));
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_session(input int count, input int mode);
    int n;
    n = (count > DEPTH) ? DEPTH : count;
    plan_session(count, 4 * n);
    start_cmd(count);
    send_bytes(mode);
    wait_done();
    end_checks(n);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_im_we"}, 32'(bus.im_we), 32'd0);
    check({tag, "_im_addr"}, 32'(bus.im_addr), 32'd0);
    check({tag, "_im_wdata"}, bus.im_wdata, 32'd0);
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_checksum"}, checksum, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    wr_session = 0;
    last_addr  = -1;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed two-word load
    sess_words.delete();
    sess_words.push_back(32'h2008_0005);
    sess_words.push_back(32'h0000_000C);
    run_session(2, 0);
    check("checksum_const", checksum, 32'h2008_0009);

    // Zero-length session goes straight to DONE
    sess_words.delete();
    run_session(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("zero_no_write", 32'(wr_session), 32'd0);

    // Single word, valid toggling every other cycle
    random_words(1);
    run_session(1, 1);

    // Abort after two bytes of word 1 of 3, with a byte offered on the abort cycle
    random_words(3);
    plan_session(1, 6);
    start_cmd(3);
    send_bytes(0);
    abort = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'($urandom);
    @(posedge clk); #1;
    abort = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_cpu_hold", 32'(cpu_hold), 32'd1);
    check("abort_byte_ready", 32'(bus.byte_ready), 32'd0);
    check("abort_writes", 32'(wr_session), 32'd1);
    check("abort_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    random_words(2);
    run_session(2, 2);

    // Randomised sessions
    for (int s = 0; s < 3; s++) begin
      int c;
      c = $urandom_range(1, 12);
      random_words(c);
      run_session(c, $urandom_range(0, 2));
    end

    // Oversized count clamps to the memory depth
    random_words(DEPTH);
    run_session(1500, 0);
    check("last_addr", 32'(last_addr), 32'(DEPTH - 1));
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hA5;
    repeat (5) @(posedge clk);
    #1;
    check("done_byte_ready", 32'(bus.byte_ready), 32'd0);
    check("done_extra_writes", 32'(wr_session), 32'(DEPTH));
    bus.byte_valid = 1'b0;

    // Reset asserted while the first word is being written
    random_words(2);
    plan_session(2, 4);
    start_cmd(2);
    send_bytes(0);
    check("write_strobe_before_reset", 32'(bus.im_we), 32'd1);
    reset = 1'b0;
    #1;
    exp_q.delete();
    reset_checks("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    random_words(3);
    run_session(3, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IM_DEPTH, default 1024: instruction memory depth in 32-bit words.
REQ-002 Parameter IM_AW, default 10: word-address width; IM_DEPTH SHALL equal 2**IM_AW.
REQ-003 Port clk  in  1: single clock; all state changes on its rising edge.
REQ-004 Port reset  in  1: asynchronous, active-low reset; a low level clears all state immediately.
REQ-005 Port start  in  1: one-cycle request to begin a load session.
REQ-006 Port abort  in  1: cancel an in-progress session.
REQ-007 Port word_count  in  11: number of words to load, sampled on an accepted start.
REQ-008 Port byte_valid  in  1: source offers byte_data.
REQ-009 Port byte_data  in  8: program byte stream, most significant byte of each word first.
REQ-010 Port byte_ready  out  1: loader can accept a byte this cycle.
REQ-011 Port im_we  out  1: write strobe to the instruction memory.
REQ-012 Port im_addr  out  IM_AW: word index being written.
REQ-013 Port im_wdata  out  32: word being written.
REQ-014 Port busy  out  1: a session is active.
REQ-015 Port done  out  1: the last session completed; sticky.
REQ-016 Port cpu_hold  out  1: holds the fetch unit in reset while high.
REQ-017 Port checksum  out  32: XOR of all words written in the current or last session.

Function
REQ-018 FSM states SHALL be IDLE, RECV, WRITE and DONE; all outputs SHALL be registered.
REQ-019 IDLE or DONE with start=1: the loader SHALL latch min(word_count, IM_DEPTH), clear the word index, byte counter and checksum, clear done, and go to RECV; if the latched count is 0 it SHALL go directly to DONE.
REQ-020 start SHALL be ignored in RECV and WRITE.
REQ-021 byte_ready SHALL be 1 only in RECV; a byte is accepted on a clock edge where byte_valid=1 and byte_ready=1.
REQ-022 Accepted bytes SHALL be shifted in big-endian order: byte 0 to [31:24], byte 3 to [7:0].
REQ-023 The edge that accepts the 4th byte SHALL move the FSM to WRITE; in the following cycle im_we=1, im_addr=index and im_wdata=the assembled word, for exactly one cycle.
REQ-024 The checksum SHALL be updated with the written word in the WRITE cycle.
REQ-025 On leaving WRITE: if index equals count-1, go to DONE; otherwise increment index and return to RECV. The index SHALL NOT wrap.
REQ-026 In DONE: done=1, busy=0, cpu_hold=0; these values SHALL persist until the next accepted start.
REQ-027 busy SHALL be 1 in RECV and WRITE, and 0 otherwise.
REQ-028 cpu_hold SHALL be 1 from reset until the first entry to DONE, and 1 in RECV, WRITE and IDLE.
REQ-029 abort=1 in RECV or WRITE SHALL return the FSM to IDLE on the next edge, suppress any pending im_we, and discard the partial word; done stays 0.
REQ-030 abort SHALL take priority over byte acceptance in the same cycle, and SHALL have no effect in IDLE or DONE.
REQ-031 im_we SHALL be 0 in every state except WRITE.

Reset
REQ-032 While reset=0: state=IDLE, im_we=0, im_addr=0, im_wdata=0, byte_ready=0, busy=0, done=0, cpu_hold=1, checksum=0, and all counters cleared.
REQ-033 Reset asserted mid-session SHALL abandon the session immediately, with no further memory write.

Structure
REQ-034 The shared package SHALL hold the state encoding, IM_DEPTH, IM_AW and the fetch reset PC constant 32'h00003000.
REQ-035 A sub-module byte_packer (4-byte shift register with 2-bit byte counter and word_full flag) SHALL be instantiated once.

Verification
REQ-036 start with word_count=2, bytes 20,08,00,05,00,00,00,0C -> im_we at addr 0 with 0x20080005, then addr 1 with 0x0000000C; done=1; checksum=0x20080009.
REQ-037 start with word_count=0 -> DONE next edge, no im_we, done=1, cpu_hold=0.
REQ-038 word_count=1 with byte_valid toggling every other cycle -> exactly one write, word correct, no byte lost or duplicated.
REQ-039 abort after 2 bytes of word 1 of 3 -> IDLE, no further im_we, done=0, cpu_hold=1; a new start then reloads from addr 0.
REQ-040 word_count=1500 -> exactly 1024 writes, last at addr 1023, then DONE.
REQ-041 reset driven low during WRITE -> im_we=0 immediately, all outputs at reset values, cpu_hold=1.
